pg_carry_resolver: RTL and testbench
====================================

PG_CARRY_RESOLVER -- requirements
Module: pg_carry_resolver

Interface
REQ-001 SHALL have parameter NUM_GROUPS, default 4, number of 4-bit P/G groups per operation; result width is 4*NUM_GROUPS.
REQ-002 SHALL use one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 in_valid  input  1  group beat present.
REQ-005 in_ready  output  1  block accepts a beat this cycle.
REQ-006 in_p  input  4  group propagate bits (A^B), bit 0 least significant.
REQ-007 in_g  input  4  group generate bits (A&B).
REQ-008 in_cin  input  1  operation carry-in, sampled only on beat 0.
REQ-009 out_valid  output  1  result held.
REQ-010 out_ready  input  1  consumer takes result.
REQ-011 out_sum  output  4*NUM_GROUPS  sum bits.
REQ-012 out_cout  output  1  carry out of MSB.
REQ-013 out_gp  output  1  whole-word propagate (AND of all P bits).
REQ-014 out_gg  output  1  whole-word generate, independent of cin.

Function
REQ-015 SHALL implement two states: COLLECT (in_ready=1, out_valid=0) and RESULT (in_ready=0, out_valid=1).
REQ-016 Beat accepted SHALL mean in_valid && in_ready at a rising clk edge; beats arrive LSB group first.
REQ-017 SHALL keep a beat counter 0..NUM_GROUPS-1 and a carry register; on beat 0 the carry-in used SHALL be in_cin, on later beats the carry register.
REQ-018 Per beat, internal carries SHALL be lookahead form: c0=carry_in, c(i+1)=g(i) | p(i)&c(i), i=0..3, computed combinationally in the same cycle.
REQ-019 Per beat, sum nibble p^{c3,c2,c1,c0} SHALL be written to out_sum bits [4k+3:4k], k=beat index; carry register <= c4.
REQ-020 Per beat, group P=&p and G=g3|p3g2|p3p2g1|p3p2p1g0 SHALL fold: gp <= gp & P (gp=1 on beat 0 start), gg <= G | P&gg (gg=0 on beat 0 start).
REQ-021 Accepting beat NUM_GROUPS-1 SHALL move to RESULT next cycle with out_cout=final c4, out_sum/out_gp/out_gg complete; latency 1 cycle after last beat.
REQ-022 In RESULT all outputs SHALL hold stable until out_ready=1; on that edge state returns to COLLECT, counter 0; no beat is accepted on that edge.
REQ-023 Gaps (in_valid=0) between beats SHALL not alter state, counter or partial results.
REQ-024 out_sum nibbles not yet written in the current operation SHALL retain prior values; only out_valid qualifies out_sum.
REQ-025 in_p/in_g/in_cin when no beat is accepted SHALL be ignored.

Reset
REQ-026 rst=1 at an edge SHALL force state COLLECT, counter 0, carry 0, out_valid 0, out_sum 0, out_cout 0, out_gp 0, out_gg 0.
REQ-027 in_ready SHALL be 0 while rst=1 and 1 the first cycle after rst deasserts.
REQ-028 Reset mid-operation (COLLECT or RESULT) SHALL discard partial beats and pending result; the next accepted beat is beat 0.

Verification
REQ-029 A=0x0005,B=0x0005,cin=0 (beats P/G: 0/5,0/0,0/0,0/0) -> out_sum=0x000A, out_cout=0, out_gp=0, out_gg=0.
REQ-030 A=0xFFFF,B=0x0001,cin=0 (E/1,F/0,F/0,F/0) -> out_sum=0x0000, out_cout=1, out_gp=0, out_gg=1.
REQ-031 A=0xFFFF,B=0x0000,cin=1 (F/0 x4) -> out_sum=0x0000, out_cout=1, out_gp=1, out_gg=0.
REQ-032 Backpressure: out_ready=0 for 3 cycles after RESULT -> out_valid=1, outputs stable, in_ready=0; out_ready=1 -> in_ready=1 next cycle, new op correct.
REQ-033 rst pulsed after 2 beats, then A=0x1234,B=0x1111,cin=0 fed as 4 beats -> out_sum=0x2345, out_cout=0.
REQ-034 Case REQ-030 with in_valid=0 cycles inserted between every beat -> identical result, out_valid one cycle after last beat.

Source files
------------

// File: rtl/pg_carry_resolver.sv
// Serial propagate/generate carry resolver.
// Takes one 4-bit P/G group per beat, LSB group first, and resolves its carries in lookahead
// form. The sum is built a nibble at a time, and the whole-word group propagate/generate is
// folded in as each beat arrives. The result is held until the consumer accepts it.
module pg_carry_resolver #(
    parameter int unsigned NUM_GROUPS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [3:0]                in_p,
    input  logic [3:0]                in_g,
    input  logic                      in_cin,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [4*NUM_GROUPS-1:0]   out_sum,
    output logic                      out_cout,
    output logic                      out_gp,
    output logic                      out_gg
);

    localparam int unsigned CW = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(NUM_GROUPS - 1);

    typedef enum logic [0:0] {StCollect, StResult} state_t;

    state_t          state_q;
    logic [CW-1:0]   beat_q;
    logic            carry_q;

    logic            first_beat;
    logic            accept;
    logic [4:0]      c;
    logic [3:0]      sum_nib;
    logic            grp_p;
    logic            grp_g;
    logic            gp_base;
    logic            gg_base;

    // Handshake is driven by the state register; reset blocks acceptance right away.
    assign in_ready   = (state_q == StCollect) && !rst;
    assign out_valid  = (state_q == StResult);
    assign accept     = in_valid && in_ready;
    assign first_beat = (beat_q == '0);

    // Lookahead carries and group P/G for the current beat.
    always_comb begin
        c       = '0;
        c[0]    = first_beat ? in_cin : carry_q;
        for (int i = 0; i < 4; i++) begin
            c[i+1] = in_g[i] | (in_p[i] & c[i]);
        end
        sum_nib = in_p ^ c[3:0];
        grp_p   = &in_p;
        grp_g   = in_g[3] | (in_p[3] & in_g[2]) | (in_p[3] & in_p[2] & in_g[1])
                | (in_p[3] & in_p[2] & in_p[1] & in_g[0]);
        // Beat 0 starts a new fold, so the previous word's gp/gg are ignored.
        gp_base = first_beat ? 1'b1 : out_gp;
        gg_base = first_beat ? 1'b0 : out_gg;
    end

    // Collect beats, then hold the result until the consumer takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StCollect;
            beat_q   <= '0;
            carry_q  <= 1'b0;
            out_sum  <= '0;
            out_cout <= 1'b0;
            out_gp   <= 1'b0;
            out_gg   <= 1'b0;
        end else begin
            unique case (state_q)
                StCollect: begin
                    if (accept) begin
                        out_sum[4*int'(beat_q) +: 4] <= sum_nib;
                        carry_q <= c[4];
                        out_gp  <= gp_base & grp_p;
                        out_gg  <= grp_g | (grp_p & gg_base);
                        if (beat_q == LAST_BEAT) begin
                            out_cout <= c[4];
                            beat_q   <= '0;
                            state_q  <= StResult;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                StResult: begin
                    if (out_ready) begin
                        state_q <= StCollect;
                        beat_q  <= '0;
                    end
                end
                default: state_q <= StCollect;
            endcase
        end
    end

endmodule

// File: tb/tb_pg_carry_resolver.sv
// Directed bench for pg_carry_resolver: a table of additions plus reset/backpressure sequences.
module tb_pg_carry_resolver;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_p;
    logic [3:0]  in_g;
    logic        in_cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_cout;
    logic        out_gp;
    logic        out_gg;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pg_carry_resolver #(.NUM_GROUPS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_p      (in_p),
        .in_g      (in_g),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_gp    (out_gp),
        .out_gg    (out_gg)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic        gp;
        logic        gg;
        bit          gaps;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Feed one 4-beat operation; beats after 0 carry an inverted cin that must be ignored.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input bit gaps);
        logic [15:0] p;
        logic [15:0] g;
        p = a ^ b;
        g = a & b;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("beat_in_ready", {31'd0, in_ready}, 32'd1);
            in_valid = 1'b1;
            in_p     = p[4*k +: 4];
            in_g     = g[4*k +: 4];
            in_cin   = (k == 0) ? cin : ~cin;
            @(posedge clk);
            if (gaps && k < 3) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_p     = 4'($urandom);
                in_g     = 4'($urandom);
                in_cin   = 1'($urandom);
                @(posedge clk);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("result_valid", {31'd0, out_valid}, 32'd1);
        check("result_in_ready", {31'd0, in_ready}, 32'd0);
    endtask

    task automatic check_result(input logic [15:0] sum, input logic cout, input logic gp,
                                input logic gg);
        check("out_sum", {16'd0, out_sum}, {16'd0, sum});
        check("out_cout", {31'd0, out_cout}, {31'd0, cout});
        check("out_gp", {31'd0, out_gp}, {31'd0, gp});
        check("out_gg", {31'd0, out_gg}, {31'd0, gg});
    endtask

    // Consume the result; optionally present a stray beat on the release edge.
    task automatic release_result(input bit stray);
        @(negedge clk);
        out_ready = 1'b1;
        if (stray) begin
            in_valid = 1'b1;
            in_p     = 4'hF;
            in_g     = 4'hF;
            in_cin   = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("release_valid", {31'd0, out_valid}, 32'd0);
        check("release_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic check_reset_state;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_sum", {16'd0, out_sum}, 32'd0);
        check("rst_cout", {31'd0, out_cout}, 32'd0);
        check("rst_gp", {31'd0, out_gp}, 32'd0);
        check("rst_gg", {31'd0, out_gg}, 32'd0);
    endtask

    initial begin
        //          a        b        cin   sum      cout  gp    gg    gaps
        vecs[0] = '{16'h0005, 16'h0005, 1'b0, 16'h000A, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{16'h00FF, 16'hFF00, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{16'h00FF, 16'hFF00, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_p      = 4'h0;
        in_g      = 4'h0;
        in_cin    = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("in_ready_during_rst", {31'd0, in_ready}, 32'd0);
        check_reset_state();
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

        // Table-driven operations
        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].gaps);
            check_result(vecs[i].sum, vecs[i].cout, vecs[i].gp, vecs[i].gg);
            release_result(1'b0);
        end

        // Backpressure: result held for 3 cycles while stray beats are offered
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_p     = 4'h5;
            in_g     = 4'hA;
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check_result(16'h0000, 1'b1, 1'b0, 1'b1);
        end
        release_result(1'b1);
        run_op(16'h0005, 16'h0005, 1'b0, 1'b0);
        check_result(16'h000A, 1'b0, 1'b0, 1'b0);
        release_result(1'b0);

        // Reset after two beats discards the partial operation
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_p     = (k == 0) ? 4'hE : 4'hF;
            in_g     = (k == 0) ? 4'h1 : 4'h0;
            in_cin   = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_reset_state();
        run_op(16'h1234, 16'h1111, 1'b0, 1'b0);
        check_result(16'h2345, 1'b0, 1'b0, 1'b0);

        // Reset while a result is pending drops it
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_reset_state();
        run_op(16'hFFFF, 16'h0000, 1'b1, 1'b1);
        check_result(16'h0000, 1'b1, 1'b1, 1'b0);
        release_result(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
